// File: rtl/aes_key_expander_seq.sv
// -----------------------------------------------------------------------------
// aes_key_expander_seq
//   Sequential AES-128 key schedule. A cipher key is latched on key_load and
//   expanded into 11 round keys, one round per clock, into an internal 11x128
//   register file. Once the schedule is complete the keys can be streamed out
//   (round 0..10) over a valid/ready handshake as many times as needed.
//
// Ports
//   clk          in   1    clock, all state on the rising edge
//   rst_n        in   1    asynchronous active-low reset
//   key_in       in   128  cipher key, w0 = key_in[127:96]
//   key_load     in   1    pulse: latch key_in and (re)start expansion
//   stream_start in   1    pulse: stream the stored schedule (READY only)
//   stream_rev   in   1    only with AES_KEYEXP_REVERSE_EN: 1 = rounds 10..0
//   busy         out  1    expansion or stream in progress
//   keys_ready   out  1    schedule valid and no stream active
//   rk_valid     out  1    rk_data holds a valid round key
//   rk_ready     in   1    consumer accepts rk_data this cycle
//   rk_data      out  128  round key
//   rk_idx       out  4    round index of rk_data
//   rk_last      out  1    final key of the stream
//
// Configuration
//   AES_KEYEXP_REVERSE_EN : adds stream_rev for decryptor-order streaming.
//                           Undefined (default): forward order only.
// -----------------------------------------------------------------------------
module aes_key_expander_seq #(
    parameter int NUM_ROUNDS = 10,
    parameter int RK_W       = 128
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [RK_W-1:0] key_in,
    input  logic            key_load,
    input  logic            stream_start,
`ifdef AES_KEYEXP_REVERSE_EN
    input  logic            stream_rev,
`endif
    output logic            busy,
    output logic            keys_ready,
    output logic            rk_valid,
    input  logic            rk_ready,
    output logic [RK_W-1:0] rk_data,
    output logic [3:0]      rk_idx,
    output logic            rk_last
);

    generate
        if (NUM_ROUNDS != 10 || RK_W != 128) begin : g_param_check
            $error("aes_key_expander_seq supports only AES-128 (NUM_ROUNDS=10, RK_W=128)");
        end
    endgenerate

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_READY  = 2'd2;
    localparam logic [1:0] ST_STREAM = 2'd3;

    localparam logic [3:0] LAST_RC  = 4'd9;
    localparam logic [3:0] LAST_IDX = 4'd10;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end else begin
                p = p;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // AES S-box computed as multiplicative inverse (x^254) plus affine map,
    // which keeps the table out of the source and maps 0 to 0x63 naturally.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        inv  = gf_mul(x252, x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rc);
        logic [7:0] r;
        case (rc)
            4'd0:    r = 8'h01;
            4'd1:    r = 8'h02;
            4'd2:    r = 8'h04;
            4'd3:    r = 8'h08;
            4'd4:    r = 8'h10;
            4'd5:    r = 8'h20;
            4'd6:    r = 8'h40;
            4'd7:    r = 8'h80;
            4'd8:    r = 8'h1b;
            4'd9:    r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    logic [1:0]      state_r;
    logic [1:0]      state_next_s;
    logic [3:0]      rc_r;
    logic [RK_W-1:0] rf_r [0:10];
    logic            rev_r;
    logic            rev_req_s;
    logic            busy_r;
    logic            keys_ready_r;
    logic            rk_valid_r;
    logic [RK_W-1:0] rk_data_r;
    logic [3:0]      rk_idx_r;
    logic            rk_last_r;

    logic [RK_W-1:0] cur_rk_s;
    logic [31:0]     t_s;
    logic [31:0]     w0_s, w1_s, w2_s, w3_s;
    logic [RK_W-1:0] next_rk_s;
    logic [3:0]      first_idx_s;
    logic [3:0]      next_idx_s;
    logic [3:0]      end_idx_s;
    logic            xfer_s;

`ifdef AES_KEYEXP_REVERSE_EN
    assign rev_req_s = stream_rev;
`else
    assign rev_req_s = 1'b0;
`endif

    assign xfer_s = rk_valid_r & rk_ready;

    // One key-schedule round: rf[rc] -> rf[rc+1].
    always_comb begin
        cur_rk_s  = rf_r[rc_r];
        t_s       = sub_word({cur_rk_s[23:0], cur_rk_s[31:24]}) ^ {rcon(rc_r), 24'h000000};
        w0_s      = cur_rk_s[127:96] ^ t_s;
        w1_s      = cur_rk_s[95:64]  ^ w0_s;
        w2_s      = cur_rk_s[63:32]  ^ w1_s;
        w3_s      = cur_rk_s[31:0]   ^ w2_s;
        next_rk_s = {w0_s, w1_s, w2_s, w3_s};
    end

    // Stream index sequencing; direction is fixed for the whole stream by rev_r.
    always_comb begin
        first_idx_s = rev_req_s ? LAST_IDX : 4'd0;
        if (rev_r) begin
            next_idx_s = rk_idx_r - 4'd1;
            end_idx_s  = 4'd0;
        end else begin
            next_idx_s = rk_idx_r + 4'd1;
            end_idx_s  = LAST_IDX;
        end
    end

    // FSM next state; key_load overrides everything else.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                state_next_s = ST_IDLE;
            end
            ST_EXPAND: begin
                if (rc_r == LAST_RC) begin
                    state_next_s = ST_READY;
                end else begin
                    state_next_s = ST_EXPAND;
                end
            end
            ST_READY: begin
                if (stream_start) begin
                    state_next_s = ST_STREAM;
                end else begin
                    state_next_s = ST_READY;
                end
            end
            ST_STREAM: begin
                if (xfer_s && rk_last_r) begin
                    state_next_s = ST_READY;
                end else begin
                    state_next_s = ST_STREAM;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
        if (key_load) begin
            state_next_s = ST_EXPAND;
        end else begin
            state_next_s = state_next_s;
        end
    end

    // State, round counter and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            rc_r         <= 4'd0;
            busy_r       <= 1'b0;
            keys_ready_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            busy_r       <= (state_next_s == ST_EXPAND) || (state_next_s == ST_STREAM);
            keys_ready_r <= (state_next_s == ST_READY);
            if (key_load) begin
                rc_r <= 4'd0;
            end else if (state_r == ST_EXPAND) begin
                rc_r <= rc_r + 4'd1;
            end else begin
                rc_r <= rc_r;
            end
        end
    end

    // Round key register file; key_load only rewrites rf[0], the rest are
    // overwritten in order during EXPAND before they can be streamed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 11; i++) begin
                rf_r[i] <= '0;
            end
        end else if (key_load) begin
            rf_r[0] <= key_in;
        end else if (state_r == ST_EXPAND) begin
            rf_r[rc_r + 4'd1] <= next_rk_s;
        end
    end

    // Output stream register: loads on start, advances on each transfer,
    // holds while stalled, and is cancelled by key_load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_valid_r <= 1'b0;
            rk_data_r  <= '0;
            rk_idx_r   <= 4'd0;
            rk_last_r  <= 1'b0;
            rev_r      <= 1'b0;
        end else if (key_load) begin
            rk_valid_r <= 1'b0;
            rk_last_r  <= 1'b0;
        end else if (state_r == ST_READY && stream_start) begin
            rk_valid_r <= 1'b1;
            rk_idx_r   <= first_idx_s;
            rk_data_r  <= rf_r[first_idx_s];
            rk_last_r  <= 1'b0;
            rev_r      <= rev_req_s;
        end else if (state_r == ST_STREAM && xfer_s) begin
            if (rk_last_r) begin
                rk_valid_r <= 1'b0;
                rk_last_r  <= 1'b0;
            end else begin
                rk_idx_r   <= next_idx_s;
                rk_data_r  <= rf_r[next_idx_s];
                rk_last_r  <= (next_idx_s == end_idx_s);
            end
        end
    end

    assign busy       = busy_r;
    assign keys_ready = keys_ready_r;
    assign rk_valid   = rk_valid_r;
    assign rk_data    = rk_data_r;
    assign rk_idx     = rk_idx_r;
    assign rk_last    = rk_last_r;

endmodule
